// File: rtl/keypad_scan_decoder.sv
// 5x5 matrix keypad scanner with scan-level debounce and newhex/newop/eq strobes.
// Optional feature: define AUTO_REPEAT_EN for hex-digit auto-repeat while held.
module keypad_scan_decoder #(
  parameter int unsigned SCAN_DIV       = 1000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] row_n,
  output logic [4:0] col_n,
  output logic       newhex,
  output logic [3:0] hexcode,
  output logic       newop,
  output logic [1:0] opcode,
  output logic       eq
);

  localparam int unsigned DivW   = $clog2(SCAN_DIV);
  localparam int unsigned CntMax = (DEBOUNCE_SCANS > REPEAT_SCANS) ? DEBOUNCE_SCANS
                                                                   : REPEAT_SCANS;
  localparam int unsigned CntW   = $clog2(CntMax + 2);

  typedef enum logic [1:0] {StIdle, StConfirm, StHeld, StReleaseWait} state_e;

  logic [4:0]      row_meta_q, row_sync_q;
  logic [DivW-1:0] div_q;
  logic [2:0]      col_q;
  logic [24:0]     snap_q, snap_d;
  logic            sample, scan_done;

  logic [4:0]      n_pressed;
  logic [2:0]      res_c, res_r;
  logic            res_valid, match;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [5:0]      cand_q, cand_d;
  logic            fire;
  logic [2:0]      key_c, key_r;
  logic            is_eq, is_op, is_hex;

  assign sample    = (div_q == DivW'(SCAN_DIV - 1));
  assign scan_done = sample && (col_q == 3'd4);
  assign col_n     = ~(5'b00001 << col_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_meta_q <= 5'h1f;
      row_sync_q <= 5'h1f;
      div_q      <= '0;
      col_q      <= 3'd0;
      snap_q     <= '0;
    end else begin
      row_meta_q <= row_n;
      row_sync_q <= row_meta_q;
      snap_q     <= snap_d;
      if (sample) begin
        div_q <= '0;
        col_q <= (col_q == 3'd4) ? 3'd0 : col_q + 3'd1;
      end else begin
        div_q <= div_q + DivW'(1);
      end
    end
  end

  // Snapshot including the column being sampled this cycle, so evaluation sees a full scan.
  always_comb begin
    snap_d = snap_q;
    for (int c = 0; c < 5; c++) begin
      if (sample && (col_q == 3'(c))) snap_d[5*c +: 5] = ~row_sync_q;
    end
  end

  always_comb begin
    n_pressed = '0;
    res_c     = 3'd0;
    res_r     = 3'd0;
    for (int c = 0; c < 5; c++) begin
      for (int r = 0; r < 5; r++) begin
        if (snap_d[5*c+r]) begin
          n_pressed = n_pressed + 5'd1;
          res_c     = 3'(c);
          res_r     = 3'(r);
        end
      end
    end
    res_valid = (n_pressed == 5'd1) && ((res_c != 3'd4) || (res_r == 3'd0));
  end

  assign match   = res_valid && ({res_c, res_r} == cand_q);
  assign cnt_inc = cnt_q + CntW'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StReleaseWait;
      cnt_q   <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
    end
  end

`ifdef AUTO_REPEAT_EN
  logic cand_is_hex;
  assign cand_is_hex = (cand_q[5:3] != 3'd4) && (cand_q[2:0] != 3'd4);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    fire    = 1'b0;
    if (scan_done) begin
      unique case (state_q)
        StIdle: begin
          if (res_valid) begin
            cand_d = {res_c, res_r};
            if (DEBOUNCE_SCANS == 1) begin
              fire    = 1'b1;
              state_d = StHeld;
              cnt_d   = '0;
            end else begin
              state_d = StConfirm;
              cnt_d   = CntW'(1);
            end
          end
        end
        StConfirm: begin
          if (match) begin
            if (cnt_inc >= CntW'(DEBOUNCE_SCANS)) begin
              fire    = 1'b1;
              state_d = StHeld;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        StHeld: begin
          if (!match) begin
            state_d = StReleaseWait;
            cnt_d   = CntW'(1);
          end
`ifdef AUTO_REPEAT_EN
          else if (cand_is_hex) begin
            if (cnt_inc >= CntW'(REPEAT_SCANS)) begin
              fire  = 1'b1;
              cnt_d = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
`endif
        end
        StReleaseWait: begin
          if (res_valid) begin
            cnt_d = '0;
          end else if (cnt_inc >= CntW'(DEBOUNCE_SCANS)) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = StReleaseWait;
      endcase
    end
  end

  always_comb begin
    key_c  = cand_d[5:3];
    key_r  = cand_d[2:0];
    is_eq  = (key_c == 3'd4);
    is_op  = !is_eq && (key_r == 3'd4);
    is_hex = !is_eq && !is_op;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      newhex  <= 1'b0;
      newop   <= 1'b0;
      eq      <= 1'b0;
      hexcode <= 4'h0;
      opcode  <= 2'b00;
    end else begin
      newhex <= fire && is_hex;
      newop  <= fire && is_op;
      eq     <= fire && is_eq;
      if (fire && is_hex) hexcode <= {key_r[1:0], key_c[1:0]};
      if (fire && is_op)  opcode  <= key_c[1:0];
    end
  end

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Scoreboard bench for keypad_scan_decoder: a keypad matrix model drives row_n from col_n,
// expected strobes are queued by the stimulus and matched by a separate monitor.
module tb_keypad_scan_decoder;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] row_n;
  logic [4:0] col_n;
  logic       newhex, newop, eq;
  logic [3:0] hexcode;
  logic [1:0] opcode;

  logic [24:0] keys;
  logic [5:0]  exp_q[$];
  int          tests = 0;
  int          fails = 0;

  localparam logic [1:0] KHex = 2'd1, KOp = 2'd2, KEq = 2'd3;

  keypad_scan_decoder #(
    .SCAN_DIV      (4),
    .DEBOUNCE_SCANS(2),
    .REPEAT_SCANS  (3)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .row_n  (row_n),
    .col_n  (col_n),
    .newhex (newhex),
    .hexcode(hexcode),
    .newop  (newop),
    .opcode (opcode),
    .eq     (eq)
  );

  always #5 clock = ~clock;

  // Keypad matrix: a pressed key shorts its row to the driven-low column.
  always_comb begin
    row_n = 5'h1f;
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 5; r++)
        if (!col_n[c] && keys[5*c+r]) row_n[r] = 1'b0;
  end

  function automatic logic [24:0] key_bit(input int c, input int r);
    logic [24:0] v;
    v = '0;
    v[5*c+r] = 1'b1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    tests++;
    if (got !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, expv);
    end
  endtask

  // Returns at the first negedge of the next scan (column 0, first dwell cycle).
  task automatic next_scan();
    logic [4:0] prev;
    int t;
    t = 0;
    prev = col_n;
    @(negedge clock);
    while (!(prev == 5'b01111 && col_n == 5'b11110)) begin
      prev = col_n;
      @(negedge clock);
      t++;
      if (t > 200) begin
        tests++;
        fails++;
        $display("FAIL scan_timeout: got no scan boundary, expected one within 200 cycles");
        break;
      end
    end
  endtask

  task automatic run_scans(input int n);
    repeat (n) next_scan();
  endtask

  task automatic hold(input logic [24:0] k, input int n);
    keys = k;
    run_scans(n);
  endtask

  task automatic check_drained(input string name);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s: %0d expected strobes missing, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every strobe must match the head of the expectation queue.
  logic [5:0] got_ev, exp_ev;
  int         n_str;
  always @(negedge clock) begin
    if (!reset) begin
      n_str = int'(newhex) + int'(newop) + int'(eq);
      if (n_str != 0) begin
        tests++;
        if (n_str > 1) begin
          fails++;
          $display("FAIL strobe_onehot: got %0d strobes together, expected 1", n_str);
        end
        if (newhex)     got_ev = {KHex, hexcode};
        else if (newop) got_ev = {KOp, 2'b00, opcode};
        else            got_ev = {KEq, 4'h0};
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_strobe: got %0h, expected none", got_ev);
        end else begin
          exp_ev = exp_q.pop_front();
          if (got_ev !== exp_ev) begin
            fails++;
            $display("FAIL strobe_value: got %0h, expected %0h", got_ev, exp_ev);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  logic [4:0] col_seq [5];

  initial begin
    col_seq = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111};
    reset = 1'b1;
    keys  = '0;
    repeat (3) @(negedge clock);
    check("reset_col_n", 32'(col_n), 32'h1e);
    check("reset_strobes", {29'b0, newhex, newop, eq}, 32'h0);
    check("reset_hexcode", 32'(hexcode), 32'h0);
    check("reset_opcode", 32'(opcode), 32'h0);
    reset = 1'b0;

    // Column walk: each column low for exactly 4 clocks, no strobes with no keys.
    for (int i = 0; i < 40; i++) begin
      check("col_walk", 32'(col_n), 32'(col_seq[(i / 4) % 5]));
      @(negedge clock);
    end
    run_scans(2);
    check_drained("idle");

    // Digit 6, held through 3 scans: exactly one strobe, value held after release.
    exp_q.push_back({KHex, 4'h6});
    hold(key_bit(2, 1), 3);
    hold('0, 4);
    check_drained("digit6");
    check("hexcode_held", 32'(hexcode), 32'h6);

    // Divide operator then equals.
    exp_q.push_back({KOp, 4'h3});
    hold(key_bit(3, 4), 3);
    hold('0, 4);
    check_drained("op_div");
    check("opcode_held", 32'(opcode), 32'h3);
    exp_q.push_back({KEq, 4'h0});
    hold(key_bit(4, 0), 3);
    hold('0, 4);
    check_drained("equals");

    // Two keys together rejected; dropping one leaves digit 0.
    hold(key_bit(0, 0) | key_bit(1, 0), 3);
    check_drained("multi_key");
    exp_q.push_back({KHex, 4'h0});
    hold(key_bit(0, 0), 3);
    hold('0, 4);
    check_drained("digit0");

    // Bouncing press never confirms; then a stable press strobes once.
    for (int i = 0; i < 3; i++) begin
      hold(key_bit(1, 1), 1);
      hold('0, 1);
    end
    check_drained("bounce");
    exp_q.push_back({KHex, 4'h5});
    hold(key_bit(1, 1), 3);
    hold('0, 4);
    check_drained("digit5");

    // Reset while digit 9 is held: no strobe until released and pressed again.
    hold(key_bit(1, 2), 1);
    repeat (7) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("midreset_hexcode", 32'(hexcode), 32'h0);
    check("midreset_opcode", 32'(opcode), 32'h0);
    check("midreset_col_n", 32'(col_n), 32'h1e);
    reset = 1'b0;
    run_scans(4);
    check_drained("held_through_reset");
    hold('0, 3);
    exp_q.push_back({KHex, 4'h9});
    hold(key_bit(1, 2), 3);
    hold('0, 4);
    check_drained("digit9_repress");

`ifdef AUTO_REPEAT_EN
    repeat (3) exp_q.push_back({KHex, 4'h9});
    hold(key_bit(1, 2), 9);
    hold('0, 4);
    check_drained("auto_repeat");
`endif

    run_scans(2);
    check_drained("final");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
